key10_bcd_encoder: RTL

Debounced 10-key to BCD encoder: the input end of the board's digit path. It takes ten raw active-high key/switch lines, synchronises and debounces them, and encodes a clean single-key press into a 4-bit BCD digit 0–9. The digit is handed downstream through a valid/ready handshake. It feeds the BCD-to-one-hot and 7-segment decode stages.

---
 rtl/key10_bcd_encoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/key10_bcd_encoder.sv
// rtl/key10_bcd_encoder.sv - debounced 10-key to BCD encoder with valid/ready output
module key10_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] key,
  input  logic       ready,
  output logic [3:0] bcd,
  output logic       valid,
  output logic       err,
  output logic       overrun
);

  // Counter value at which a candidate has been seen DEBOUNCE_CYCLES times in a row
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_HELD     = 1'b1
  } state_t;

  logic [9:0]    s1;
  logic [9:0]    s2;
  logic [9:0]    cand;
  logic [9:0]    stab;
  logic [CW-1:0] cnt;

  state_t        state;
  state_t        state_nxt;
  logic          press_evt;
  logic          multi_evt;
  logic [3:0]    press_idx;
  logic          stab_any;
  logic          stab_multi;

  // Two-flop synchroniser per key line; nothing downstream touches key directly
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // Debouncer: any change restarts the count, a full run of identical samples commits to stab
  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= '0;
      cnt  <= '0;
      stab <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end else begin
      stab <= cand;
    end
  end

  // Classify the debounced state and find the index of the lowest set bit
  always_comb begin
    stab_any   = |stab;
    stab_multi = (stab & (stab - 10'd1)) != 10'd0;
    press_idx  = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (stab[i]) begin
        press_idx = 4'(i);
      end
    end
  end

  // Press FSM next-state: one event per press, then wait for a full release
  always_comb begin
    state_nxt = state;
    press_evt = 1'b0;
    multi_evt = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (stab_any) begin
          state_nxt = ST_HELD;
          if (stab_multi) begin
            multi_evt = 1'b1;
          end else begin
            press_evt = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (!stab_any) begin
          state_nxt = ST_RELEASED;
        end
      end
      default: state_nxt = ST_RELEASED;
    endcase
  end

  // Press FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RELEASED;
    end else begin
      state <= state_nxt;
    end
  end

  // Output stage: load on press when the slot is free or draining, else flag the drop
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd     <= 4'd0;
      valid   <= 1'b0;
      err     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      err <= multi_evt;
      if (press_evt) begin
        if (!valid || ready) begin
          bcd   <= press_idx;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
